// File: rtl/layer_sequencer.sv
// layer_sequencer: runs conv1 -> conv2 -> conv3 and, between layers, streams
// each layer's output memory into the next layer's input memory one word per
// cycle. The host only loads layer-1 data and weights and pulses start.
module layer_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int COPY12_LEN = 8192,
    parameter int COPY23_LEN = 1024
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [2:0]        conv_finish,
    output logic [2:0]        en_conv,
    output logic [2:0]        rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [1:0]        wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        layer,
    output logic              busy,
    output logic              done
);

    // One extra counter bit so a copy of 2^ADDR_W words reaches its terminal count.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LEN12 = CW'(COPY12_LEN);
    localparam logic [CW-1:0] LEN23 = CW'(COPY23_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN1, S_COPY1, S_RUN2, S_COPY2, S_RUN3, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        en_conv_q, en_conv_d;
    logic [2:0]        rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        layer_q, layer_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_copy, rd_active, in_copy_next, rd_next;
    logic [CW-1:0]     cur_len, next_len;

    // Next state, copy counter and the next value of every registered output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        en_conv_d    = 3'b000;
        rd_sel_d     = 3'b000;
        rd_addr_d    = '0;
        wr_en_d      = 2'b00;
        wr_addr_d    = '0;
        layer_d      = 2'd0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        // A read is issued in the current cycle while the counter is below the length.
        in_copy   = (state_q == S_COPY1) || (state_q == S_COPY2);
        cur_len   = (state_q == S_COPY2) ? LEN23 : LEN12;
        rd_active = in_copy && (cnt_q < cur_len);

        unique case (state_q)
            S_IDLE:  if (start)          state_d = S_RUN1;
            S_RUN1:  if (conv_finish[0]) state_d = S_COPY1;
            S_COPY1: if (!rd_active)     state_d = S_RUN2;
            S_RUN2:  if (conv_finish[1]) state_d = S_COPY2;
            S_COPY2: if (!rd_active)     state_d = S_RUN3;
            S_RUN3:  if (conv_finish[2]) state_d = S_FIN;
            S_FIN:                       state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase

        // Counter advances only while reads remain; it is zero on every copy entry.
        if (rd_active) cnt_d = cnt_q + 1'b1;

        // Read side for the next cycle, derived from the next state and count.
        in_copy_next = (state_d == S_COPY1) || (state_d == S_COPY2);
        next_len     = (state_d == S_COPY2) ? LEN23 : LEN12;
        rd_next      = in_copy_next && (cnt_d < next_len);
        if (rd_next) begin
            rd_sel_d  = (state_d == S_COPY1) ? 3'b001 : 3'b010;
            rd_addr_d = cnt_d[ADDR_W-1:0];
        end

        // Write side trails the read by one cycle, matching the memory read latency.
        if (rd_active) begin
            wr_en_d   = (state_q == S_COPY1) ? 2'b01 : 2'b10;
            wr_addr_d = cnt_q[ADDR_W-1:0];
        end

        unique case (state_d)
            S_RUN1:  begin en_conv_d = 3'b001; layer_d = 2'd1; end
            S_COPY1: layer_d = 2'd1;
            S_RUN2:  begin en_conv_d = 3'b010; layer_d = 2'd2; end
            S_COPY2: layer_d = 2'd2;
            S_RUN3:  begin en_conv_d = 3'b100; layer_d = 2'd3; end
            S_FIN:   begin layer_d = 2'd3; done_d = 1'b1; end
            default: layer_d = 2'd0;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            en_conv_q <= 3'b000;
            rd_sel_q  <= 3'b000;
            rd_addr_q <= '0;
            wr_en_q   <= 2'b00;
            wr_addr_q <= '0;
            layer_q   <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_conv_q <= en_conv_d;
            rd_sel_q  <= rd_sel_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            layer_q   <= layer_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign en_conv = en_conv_q;
    assign rd_sel  = rd_sel_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign layer   = layer_q;
    assign busy    = busy_q;
    assign done    = done_q;
    // rd_data already comes out of the memory's read register and lines up with
    // the registered write strobe; it is forced to zero whenever no write is issued.
    assign wr_data = (wr_en_q != 2'b00) ? rd_data : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (copy lengths 4/2 and 4/0) share
// start/reset; a phase-level model predicts every output each cycle, and
// hand-computed literals pin run latency, copy lengths and copied data.
module tb_layer_sequencer;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic nreset = 1'b1;
    logic start = 1'b0;
    logic [2:0] inject = 3'b000;
    logic [2:0] cf [2];
    logic [2:0] en_conv_o [2];
    logic [2:0] rd_sel_o [2];
    logic [AW-1:0] rd_addr_o [2];
    logic [AW-1:0] wr_addr_o [2];
    logic [DW-1:0] rd_data_i [2];
    logic [DW-1:0] wr_data_o [2];
    logic [1:0] wr_en_o [2];
    logic [1:0] layer_o [2];
    logic busy_o [2];
    logic done_o [2];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.ADDR_W(AW), .DATA_W(DW), .COPY12_LEN(4), .COPY23_LEN(2)) u_dut0 (
        .clk(clk), .nreset(nreset), .start(start), .conv_finish(cf[0]),
        .en_conv(en_conv_o[0]), .rd_sel(rd_sel_o[0]), .rd_addr(rd_addr_o[0]),
        .rd_data(rd_data_i[0]), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]),
        .wr_data(wr_data_o[0]), .layer(layer_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    layer_sequencer #(.ADDR_W(AW), .DATA_W(DW), .COPY12_LEN(4), .COPY23_LEN(0)) u_dut1 (
        .clk(clk), .nreset(nreset), .start(start), .conv_finish(cf[1]),
        .en_conv(en_conv_o[1]), .rd_sel(rd_sel_o[1]), .rd_addr(rd_addr_o[1]),
        .rd_data(rd_data_i[1]), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]),
        .wr_data(wr_data_o[1]), .layer(layer_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    // Conv output memories: registered read, word = addr + 0x10 (layer 1) or + 0x50 (layer 2).
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++)
            rd_data_i[j] <= rd_addr_o[j][7:0] + (rd_sel_o[j][1] ? 8'h50 : 8'h10);
    end

    // Phase model: 0 idle, 1 running layer, 2 copying after layer, 3 finished.
    int m_phase [2] = '{0, 0};
    int m_layer [2] = '{0, 0};
    int m_t [2] = '{0, 0};

    function automatic int copy_len(int j, int ly);
        if (ly == 1) return 4;
        return (j == 0) ? 2 : 0;
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int j = 0; j < 2; j++) begin
                m_phase[j] <= 0; m_layer[j] <= 0; m_t[j] <= 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                case (m_phase[j])
                    0: if (start) begin m_phase[j] <= 1; m_layer[j] <= 1; end
                    1: if (cf[j][m_layer[j]-1]) begin
                           m_phase[j] <= (m_layer[j] == 3) ? 3 : 2;
                           m_t[j] <= 0;
                       end
                    2: if (m_t[j] >= copy_len(j, m_layer[j])) begin
                           m_phase[j] <= 1; m_layer[j] <= m_layer[j] + 1; m_t[j] <= 0;
                       end else m_t[j] <= m_t[j] + 1;
                    default: begin m_phase[j] <= 0; m_layer[j] <= 0; end
                endcase
            end
        end
    end

    // Expected {en_conv, rd_sel, rd_addr, wr_en, wr_addr, wr_data, layer, busy, done}.
    function automatic logic [51:0] exp_out(int j);
        int ph, ly, t, len;
        logic [2:0] e_en, e_sel;
        logic [15:0] e_ra, e_wa;
        logic [1:0] e_we, e_ly;
        logic [7:0] e_wd;
        ph = m_phase[j]; ly = m_layer[j]; t = m_t[j];
        len = copy_len(j, ly);
        e_en = 3'b000; e_sel = 3'b000; e_ra = 16'h0; e_wa = 16'h0;
        e_we = 2'b00; e_wd = 8'h00;
        if (ph == 1) e_en = 3'(1 << (ly - 1));
        if (ph == 2 && t < len) begin
            e_sel = 3'(1 << (ly - 1)); e_ra = 16'(t);
        end
        if (ph == 2 && t >= 1 && t <= len) begin
            e_we = 2'(1 << (ly - 1)); e_wa = 16'(t - 1);
            e_wd = 8'(t - 1 + ((ly == 1) ? 16 : 80));
        end
        e_ly = (ph == 0) ? 2'd0 : ((ph == 3) ? 2'd3 : 2'(ly));
        return {e_en, e_sel, e_ra, e_we, e_wa, e_wd, e_ly, ph != 0, ph == 3};
    endfunction

    function automatic logic [51:0] act_out(int j);
        return {en_conv_o[j], rd_sel_o[j], rd_addr_o[j], wr_en_o[j], wr_addr_o[j],
                wr_data_o[j], layer_o[j], busy_o[j], done_o[j]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-run statistics gathered from the DUT outputs.
    int busy_cnt [2], done_cnt [2], done_at [2], copy1_cnt [2], copy2_cnt [2];
    int sel2_cnt [2], run_cnt [2];
    logic [31:0] en_seq;
    logic [2:0] en_last;
    logic [7:0] mem2 [4];
    logic [7:0] mem3 [2];

    task automatic clear_stats();
        for (int j = 0; j < 2; j++) begin
            busy_cnt[j] = 0; done_cnt[j] = 0; done_at[j] = 0;
            copy1_cnt[j] = 0; copy2_cnt[j] = 0; sel2_cnt[j] = 0;
        end
        en_seq = 32'h0; en_last = 3'b000;
        for (int i = 0; i < 4; i++) mem2[i] = 8'h00;
        for (int i = 0; i < 2; i++) mem3[i] = 8'h00;
    endtask

    // One cycle: compare against the model, collect stats, drive conv_finish.
    task automatic tick();
        @(negedge clk);
        for (int j = 0; j < 2; j++)
            check($sformatf("dut%0d_outputs", j), 64'(act_out(j)), 64'(exp_out(j)));
        for (int j = 0; j < 2; j++) begin
            if (busy_o[j]) busy_cnt[j]++;
            if (done_o[j]) begin done_cnt[j]++; done_at[j] = busy_cnt[j]; end
            if (busy_o[j] && layer_o[j] == 2'd1 && en_conv_o[j] == 3'b000) copy1_cnt[j]++;
            if (busy_o[j] && layer_o[j] == 2'd2 && en_conv_o[j] == 3'b000) copy2_cnt[j]++;
            if (rd_sel_o[j][1] || wr_en_o[j][1]) sel2_cnt[j]++;
            if (en_conv_o[j] != 3'b000) run_cnt[j]++; else run_cnt[j] = 0;
            cf[j] = ((run_cnt[j] == 10) ? en_conv_o[j] : 3'b000) | inject;
        end
        if (en_conv_o[0] != en_last) begin
            en_seq = (en_seq << 4) | 32'(en_conv_o[0]);
            en_last = en_conv_o[0];
        end
        if (wr_en_o[0][0] && wr_addr_o[0] < 16'd4) mem2[wr_addr_o[0][1:0]] = wr_data_o[0];
        if (wr_en_o[0][1] && wr_addr_o[0] < 16'd2) mem3[wr_addr_o[0][0]] = wr_data_o[0];
    endtask

    task automatic run_full(bit hold_start, bit do_inject);
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done_cnt[0] > 0 && done_cnt[1] > 0 && !busy_o[0] && !busy_o[1]) break;
            inject = (do_inject && en_conv_o[0] == 3'b001 && run_cnt[0] == 3) ? 3'b100 : 3'b000;
            start = hold_start && (layer_o[0] == 2'd2);
            tick();
        end
        inject = 3'b000;
        start = 1'b0;
    endtask

    task automatic run_checks();
        check("dut0_latency", 64'(done_at[0]), 64'd39);
        check("dut1_latency", 64'(done_at[1]), 64'd37);
        check("dut0_done_pulses", 64'(done_cnt[0]), 64'd1);
        check("dut1_done_pulses", 64'(done_cnt[1]), 64'd1);
        check("copy1_cycles", 64'(copy1_cnt[0]), 64'd5);
        check("copy2_cycles", 64'(copy2_cnt[0]), 64'd3);
        check("copy2_zero_len_cycles", 64'(copy2_cnt[1]), 64'd1);
        check("zero_len_no_layer2_traffic", 64'(sel2_cnt[1]), 64'd0);
        check("en_conv_sequence", 64'(en_seq), 64'h102040);
        check("mem2_contents", 64'({mem2[3], mem2[2], mem2[1], mem2[0]}), 64'h13121110);
        check("mem3_contents", 64'({mem3[1], mem3[0]}), 64'h5150);
    endtask

    initial begin
        bit found;
        cf[0] = 3'b000; cf[1] = 3'b000;
        run_cnt[0] = 0; run_cnt[1] = 0;
        clear_stats();
        #1 nreset = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        repeat (20) tick();
        check("idle_dut0_zero", 64'(act_out(0)), 64'h0);
        check("idle_dut1_zero", 64'(act_out(1)), 64'h0);

        // Clean run, then one with start held in layer 2 and a stray finish in layer 1.
        run_full(1'b0, 1'b0);
        run_checks();
        run_full(1'b1, 1'b1);
        run_checks();

        // Abort in the middle of the first copy, at word 2.
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (rd_sel_o[0] == 3'b001 && rd_addr_o[0] == 16'd2) found = 1'b1;
        end
        check("reached_copy1_word2", 64'(found), 64'd1);
        #2 nreset = 1'b0;
        #1;
        check("async_reset_dut0_zero", 64'(act_out(0)), 64'h0);
        check("async_reset_dut1_zero", 64'(act_out(1)), 64'h0);
        tick();
        tick();
        nreset = 1'b1;
        repeat (5) tick();
        run_full(1'b0, 1'b0);
        run_checks();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level scheduler for the three convolution layers.
- Runs conv1, conv2 and conv3 in order by driving the one-hot en_conv bus.
- Between layers, copies each layer's output memory into the next layer's input memory through a one-word-per-cycle copy engine.
- Sits beside the SPI controller. It replaces manual host stepping of layers, so the host only loads layer-1 data and weights, then pulses start.

Parameters:
- ADDR_W, 16, width of all memory addresses
- DATA_W, 8, width of activation words
- COPY12_LEN, 8192, words copied from conv1 output memory to input memory 2
- COPY23_LEN, 1024, words copied from conv2 output memory to input memory 3

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run the full network; sampled only in IDLE
- conv_finish  in  3  finish flags from the three conv controllers (bit k = layer k+1)
- en_conv  out  3  one-hot conv enable, held high for the whole layer run
- rd_sel  out  3  one-hot select of the conv output memory being read
- rd_addr  out  ADDR_W  read address to the selected conv output memory
- rd_data  in  DATA_W  read data, valid 1 cycle after rd_addr
- wr_en  out  2  write enable: bit0 = input memory 2, bit1 = input memory 3
- wr_addr  out  ADDR_W  write address to input memory 2/3
- wr_data  out  DATA_W  write data
- layer  out  2  current layer: 0 = idle, 1..3 = active layer
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the full network completes

Behaviour:
- Reset (async, nreset=0): all outputs are 0, state is IDLE, all counters are 0. Assertion mid-operation aborts immediately. No resume; a new start is required.
- States: IDLE, RUN1, COPY1, RUN2, COPY2, RUN3, FIN.
- IDLE: start=1 -> RUN1 next cycle. start in any other state is ignored.
- RUNk: en_conv = one-hot bit k-1 (RUN1 -> 3'b001); layer = k.
  - First cycle with conv_finish[k-1]=1 -> COPYk (RUN3 -> FIN).
  - en_conv is 0 from the next cycle onward; at least one idle cycle separates layers.
  - conv_finish bits of other layers are ignored.
- COPYk (k=1,2): layer = k. rd_sel is one-hot k-1. wr_en drives bit k-1 only. Length L = COPY12_LEN or COPY23_LEN.
- COPYk, read side:
  - Read counter i runs 0..L-1, one per cycle; rd_addr = i.
  - The counter is cleared on entry to COPYk.
- COPYk, write side (one-stage pipeline):
  - wr_addr = i delayed 1 cycle; wr_data = rd_data; the wr_en bit is the delayed read-valid.
  - The first write occurs on the 2nd cycle of COPYk; the last write (addr L-1) on cycle L+1.
- COPYk exit: after the last write retires -> RUN(k+1). Total COPYk duration is exactly L+1 cycles, no bubbles.
- L=0 edge case: no read or write is issued; COPYk lasts 1 cycle.
- FIN: done=1 for exactly 1 cycle, busy=1, layer=3 -> IDLE. busy=0 in IDLE.
- Output timing: rd_addr, wr_addr, wr_data, wr_en, rd_sel and en_conv are registered outputs (no combinational path from inputs).
- Idle values: outside COPY states, rd_sel=0, wr_en=0, rd_addr=0, wr_addr=0.
- Counter sizing: counter width is ADDR_W+1, so L = 2^ADDR_W does not wrap before terminal compare.
- Simultaneous events:
  - conv_finish high on the same cycle RUNk is entered counts as finish; exit follows next cycle.
  - start concurrent with FIN is ignored.
- Invariant: en_conv and wr_en are never nonzero in the same cycle.

Test Plan:
- Reset/idle: nreset low 3 cycles, then high with no start -> all outputs 0, busy=0, layer=0 for 20 cycles.
- Full run, COPY12_LEN=4, COPY23_LEN=2; finish pulses after 10 cycles of each RUN:
  - en_conv sequence 001, 000, 010, 000, 100.
  - COPY1 lasts 5 cycles with wr_addr 0..3; COPY2 lasts 3 cycles.
  - done pulses once; total latency matches the sum of state durations.
- Copy data integrity: model output memory with rd_data = rd_addr+8'h10 delayed 1 cycle -> input memory 2 receives 10,11,12,13 at addresses 0..3, with wr_en=2'b01 only.
- Ignored inputs: start held high during RUN2, plus conv_finish[2] pulsed during RUN1 -> no restart, no early exit; sequence identical to the clean run.
- Reset mid-COPY1 at word 2 -> outputs 0 asynchronously and state IDLE; a new start replays from RUN1 with COPY counters restarting at 0.
- Zero length, COPY23_LEN=0 -> COPY2 lasts 1 cycle with no rd_sel/wr_en activity; RUN3 follows.
